rx_update_dispatcher: RTL
=========================

RX_UPDATE_DISPATCHER -- requirements
Module: rx_update_dispatcher

Interface
REQ-001 Parameter MAX_NUM_PROCS, default 8: number of compute-unit (PE) input FIFOs.
REQ-002 Parameter DATA_WIDTH, default 32: key and value width; an update word is 2*DATA_WIDTH = 64 bits, {key,val}.
REQ-003 Parameter MAX_NUM_WORKERS, default 4: number of worker receive FIFOs.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_ext_update_q  input  64 x MAX_NUM_WORKERS (unpacked array)  worker receive FIFO read data, valid the cycle after rdreq (non-show-ahead).
REQ-007 rx_ext_update_empty  input  MAX_NUM_WORKERS  per-worker FIFO empty.
REQ-008 rx_ext_update_rdreq  output  MAX_NUM_WORKERS  registered per-worker read request, one-hot or zero.
REQ-009 pe_fifo_data  output  64  registered {key,val} to all PE input FIFOs.
REQ-010 pe_fifo_wrreq  output  MAX_NUM_PROCS  registered per-PE write enable, one-hot or zero.
REQ-011 pe_fifo_full  input  MAX_NUM_PROCS  per-PE FIFO full.
REQ-012 log_2_num_workers_in  input  32  log2 of active workers; key bits below this select the worker and are skipped for PE routing.
REQ-013 log_2_num_procs_in  input  32  log2 of active PEs.
REQ-014 update_count  output  32  registered count of words written to PE FIFOs.

Function
REQ-015 FSM states IDLE, READ_KEYVAL, FINISH_READ, WRITE_KEYVAL; any other encoding SHALL go to IDLE next cycle.
REQ-016 IDLE: if rx_ext_update_empty[cur_worker]==0, go READ_KEYVAL and assert rx_ext_update_rdreq[cur_worker] next cycle for exactly one cycle; else advance cur_worker, stay IDLE.
REQ-017 READ_KEYVAL: unconditionally go FINISH_READ.
REQ-018 FINISH_READ: latch key=q[cur_worker][63:32], val=q[cur_worker][31:0]; go WRITE_KEYVAL.
REQ-019 Target PE tgt_pe = (key >> log_2_num_workers_in) & ~(all-ones << log_2_num_procs_in), truncated to log2(MAX_NUM_PROCS) bits.
REQ-020 WRITE_KEYVAL: if pe_fifo_full[tgt_pe]==0, assert pe_fifo_wrreq[tgt_pe] next cycle for one cycle, increment update_count, advance cur_worker, go IDLE; else hold state, key, val, cur_worker.
REQ-021 pe_fifo_data SHALL equal {key,val} continuously from FINISH_READ+1 until the next latch; stable whenever pe_fifo_wrreq is nonzero.
REQ-022 Worker round-robin: cur_worker wraps to 0 after (2**log_2_num_workers_in)-1; if that exceeds MAX_NUM_WORKERS, wrap after MAX_NUM_WORKERS-1.
REQ-023 Latency: empty deasserted seen in IDLE at cycle T -> rdreq high T+1 -> key latched end T+2 -> wrreq high T+4 (target not full); throughput one word per 4 cycles max.
REQ-024 At most one rdreq bit and one wrreq bit high in any cycle; rdreq and wrreq never high in the same cycle.
REQ-025 Full asserted while in WRITE_KEYVAL stalls indefinitely without data loss or duplicate write; empty changes after the read decision are ignored.
REQ-026 update_count wraps modulo 2**32.
REQ-027 log_2_num_workers_in=0 routes all words using key bits from bit 0; log_2_num_procs_in=0 routes all words to PE 0.
REQ-028 Configuration inputs SHALL be sampled every cycle; changing them mid-transfer is undefined except that no more than one write per read occurs.

Reset
REQ-029 While reset low: state=IDLE, cur_worker=0, key=0, val=0, rx_ext_update_rdreq=0, pe_fifo_wrreq=0, update_count=0, asynchronously.
REQ-030 Reset asserted mid-transfer SHALL abandon the in-flight word (no write), and after release the block SHALL resume polling from worker 0 on the first clk edge.

Verification
REQ-031 Worker 0 holds {32'h0000_0015, 32'h3F80_0000}, log2 workers=2, log2 procs=3: rdreq[0] at T+1, pe_fifo_wrreq=8'b0010_0000 (PE 5) at T+4, data 64'h0000_0015_3F80_0000, update_count=1.
REQ-032 Workers 0..3 each non-empty with one word: reads occur in order 0,1,2,3, each 4 cycles apart, update_count=4, all FIFOs then empty.
REQ-033 Target PE 2 full for 10 cycles in WRITE_KEYVAL: no wrreq for 10 cycles, single wrreq[2] after full drops, data unchanged.
REQ-034 Reset low during FINISH_READ: all outputs 0 immediately, no wrreq ever issued for that word, next read targets worker 0.
REQ-035 log2 workers=1, only worker 3 non-empty: worker 3 never read, cur_worker cycles 0,1.
REQ-036 1000 random words, random full/empty: every word delivered once to computed PE, per-worker order preserved, update_count=1000.

Source files
------------

// File: rtl/rx_update_dispatcher.sv
// Drains worker receive FIFOs round-robin and forwards each {key,val} update
// word to the compute-unit FIFO selected by the key bits above the worker field.
module rx_update_dispatcher #(
  parameter int MAX_NUM_PROCS   = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_NUM_WORKERS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2*DATA_WIDTH-1:0]      rx_ext_update_q [MAX_NUM_WORKERS],
  input  logic [MAX_NUM_WORKERS-1:0]   rx_ext_update_empty,
  output logic [MAX_NUM_WORKERS-1:0]   rx_ext_update_rdreq,
  output logic [2*DATA_WIDTH-1:0]      pe_fifo_data,
  output logic [MAX_NUM_PROCS-1:0]     pe_fifo_wrreq,
  input  logic [MAX_NUM_PROCS-1:0]     pe_fifo_full,
  input  logic [31:0]                  log_2_num_workers_in,
  input  logic [31:0]                  log_2_num_procs_in,
  output logic [31:0]                  update_count
);

  localparam int WW = (MAX_NUM_WORKERS > 1) ? $clog2(MAX_NUM_WORKERS) : 1;
  localparam int PW = (MAX_NUM_PROCS > 1) ? $clog2(MAX_NUM_PROCS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_KEYVAL,
    FINISH_READ,
    WRITE_KEYVAL
  } state_e;

  state_e                       state_q, state_d;
  logic [WW-1:0]                cur_worker_q, cur_worker_d;
  logic [WW-1:0]                next_worker;
  logic [DATA_WIDTH-1:0]        key_q, key_d;
  logic [DATA_WIDTH-1:0]        val_q, val_d;
  logic [MAX_NUM_WORKERS-1:0]   rdreq_q, rdreq_d;
  logic [MAX_NUM_PROCS-1:0]     wrreq_q, wrreq_d;
  logic [31:0]                  count_q, count_d;
  logic [31:0]                  worker_lim;
  logic [PW-1:0]                tgt_pe;
  logic [2*DATA_WIDTH-1:0]      rd_word;

  assign rd_word = rx_ext_update_q[cur_worker_q];

  // Last polled worker is the smaller of the configured and the physical count.
  always_comb begin
    worker_lim = 32'(MAX_NUM_WORKERS - 1);
    if ((log_2_num_workers_in < 32'd31) &&
        (((32'd1 << log_2_num_workers_in) - 32'd1) < worker_lim)) begin
      worker_lim = (32'd1 << log_2_num_workers_in) - 32'd1;
    end
  end

  // >= rather than == so a live reconfiguration can never strand the pointer.
  assign next_worker = (32'(cur_worker_q) >= worker_lim) ? '0 : cur_worker_q + WW'(1);

  assign tgt_pe = PW'((key_q >> log_2_num_workers_in) &
                      ~({DATA_WIDTH{1'b1}} << log_2_num_procs_in));

  always_comb begin
    state_d      = state_q;
    cur_worker_d = cur_worker_q;
    key_d        = key_q;
    val_d        = val_q;
    rdreq_d      = '0;
    wrreq_d      = '0;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (!rx_ext_update_empty[cur_worker_q]) begin
          rdreq_d[cur_worker_q] = 1'b1;
          state_d               = READ_KEYVAL;
        end else begin
          cur_worker_d = next_worker;
        end
      end
      READ_KEYVAL: begin
        state_d = FINISH_READ;
      end
      FINISH_READ: begin
        key_d   = rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
        val_d   = rd_word[DATA_WIDTH-1:0];
        state_d = WRITE_KEYVAL;
      end
      WRITE_KEYVAL: begin
        if (!pe_fifo_full[tgt_pe]) begin
          wrreq_d[tgt_pe] = 1'b1;
          count_d         = count_q + 32'd1;
          cur_worker_d    = next_worker;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_worker_q <= '0;
      key_q        <= '0;
      val_q        <= '0;
      rdreq_q      <= '0;
      wrreq_q      <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_worker_q <= cur_worker_d;
      key_q        <= key_d;
      val_q        <= val_d;
      rdreq_q      <= rdreq_d;
      wrreq_q      <= wrreq_d;
      count_q      <= count_d;
    end
  end

  assign rx_ext_update_rdreq = rdreq_q;
  assign pe_fifo_wrreq       = wrreq_q;
  assign pe_fifo_data        = {key_q, val_q};
  assign update_count        = count_q;

endmodule
